// File: rtl/countdown_multi.sv
// countdown_multi: interval timer with one-shot/periodic modes, pause/resume and a saturating period counter.
// Ports: clk, reset (async, active-high); clkena gates every state change (stat_done still clears).
//   ctrl_time/ctrl_mode/ctrl_div are latched at start; ctrl_run starts from IDLE; ctrl_pause holds
//   the count while high; ctrl_abort stops without completion.
//   stat_left = count, stat_busy = RUN|PAUSE, stat_paused = PAUSE, stat_done = end-of-interval pulse,
//   stat_periods = intervals completed since the last start.
// Define COUNTDOWN_MULTI_PRESCALE_EN to add a prescaler: one tick every ctrl_div+1 enabled cycles.
module countdown_multi #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 8,
  parameter int PWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkena,
  input  logic [WIDTH-1:0]  ctrl_time,
  input  logic              ctrl_mode,
  input  logic [PWIDTH-1:0] ctrl_div,
  input  logic              ctrl_run,
  input  logic              ctrl_pause,
  input  logic              ctrl_abort,
  output logic [WIDTH-1:0]  stat_left,
  output logic              stat_busy,
  output logic              stat_paused,
  output logic              stat_done,
  output logic [CWIDTH-1:0] stat_periods
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] cnt, reload;
  logic [CWIDTH-1:0] periods;
  logic mode, done_q, busy, start, zero_run, active, tick, fire, last;
  assign busy = state != IDLE;
  assign start = clkena && !busy && ctrl_run && ctrl_time != '0;
  assign zero_run = clkena && !busy && ctrl_run && ctrl_time == '0;
  // A busy cycle with pause low counts, including the cycle that leaves PAUSE.
  assign active = clkena && busy && !ctrl_abort && !ctrl_pause;
  assign fire = active && tick;
  assign last = fire && cnt == WIDTH'(1);
`ifdef COUNTDOWN_MULTI_PRESCALE_EN
  logic [PWIDTH-1:0] pre, div_q;
  assign tick = clkena && pre == div_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre <= '0;
      div_q <= '0;
    end else if (start) begin
      pre <= '0;
      div_q <= ctrl_div;
    end else if (clkena && busy && ctrl_abort) pre <= '0;
    else if (active) pre <= tick ? '0 : pre + 1'b1;
`else
  logic unused_div;
  assign unused_div = ^ctrl_div;
  assign tick = clkena;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = start ? RUN
            : (!clkena || !busy) ? state
            : ctrl_abort ? IDLE
            : ctrl_pause ? PAUSE
            : (last && !mode) ? IDLE
            : RUN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      reload <= '0;
      periods <= '0;
      mode <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= zero_run || last;
      if (start) begin
        cnt <= ctrl_time;
        reload <= ctrl_time;
        mode <= ctrl_mode;
      end else if (fire) cnt <= last ? (mode ? reload : '0) : cnt - 1'b1;
      if (start || zero_run) periods <= '0;
      else if (last && periods != '1) periods <= periods + 1'b1;
    end
  always_comb begin
    stat_left = cnt;
    stat_busy = busy;
    stat_paused = state == PAUSE;
    stat_done = done_q;
    stat_periods = periods;
  end
endmodule
